// File: rtl/axil_cnt_pkg.sv
// Shared encodings for the AXI-Lite counter bridge: response codes, read FSM
// states and the data word returned when a channel handshake times out.
package axil_cnt_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_DEAD;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        REQ,
        RELEASE,
        RESP
    } rd_state_t;

endpackage

// File: rtl/axil_cnt_bridge_if.sv
// AXI4-Lite slave bus of the counter bridge; the bridge takes the slave view,
// the interconnect (or a bench) drives the master view.
interface axil_cnt_bridge_if;

    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;

    modport slave (
        input  s_araddr, s_arvalid, s_rready,
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_arready, s_rdata, s_rresp, s_rvalid,
        output s_awready, s_wready, s_bresp, s_bvalid
    );

    modport master (
        output s_araddr, s_arvalid, s_rready,
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_arready, s_rdata, s_rresp, s_rvalid,
        input  s_awready, s_wready, s_bresp, s_bvalid
    );

endinterface

// File: rtl/axil_cnt_wr_sink.sv
// Write-reject path of the counter bridge: accepts AW and W beats in any order
// and answers each pair with a single SLVERR write response.
module axil_cnt_wr_sink
    import axil_cnt_pkg::*;
(
    input  logic              coreclk,
    input  logic              corerstn,
    axil_cnt_bridge_if.slave  bus
);

    logic aw_got;
    logic w_got;
    logic bvalid_q;
    logic unused_payload;

    assign unused_payload = ^{bus.s_awaddr, bus.s_wdata, bus.s_wstrb};

    assign bus.s_awready = !aw_got;
    assign bus.s_wready  = !w_got;
    assign bus.s_bvalid  = bvalid_q;
    assign bus.s_bresp   = bvalid_q ? RESP_SLVERR : RESP_OKAY;

    // Each address/data beat is held until the B handshake frees both channels.
    always_ff @(posedge coreclk or negedge corerstn) begin
        if (!corerstn) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            bvalid_q <= 1'b0;
        end else if (bvalid_q && bus.s_bready) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            if (bus.s_awvalid && !aw_got) begin
                aw_got <= 1'b1;
            end
            if (bus.s_wvalid && !w_got) begin
                w_got <= 1'b1;
            end
            if (aw_got && w_got) begin
                bvalid_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_cnt_bridge.sv
// AXI4-Lite read bridge onto NUM_CH 4-phase req/ack counter channels.
// Optional handshake timeout and timeout_sticky output: define CNT_TIMEOUT_EN.
module axil_cnt_bridge
    import axil_cnt_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int EXT_ADDR_W  = 32,
    parameter int DATA_W      = 32,
    parameter int CH_SEL_LSB  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         coreclk,
    input  logic                         corerstn,
    axil_cnt_bridge_if.slave             s_axil,
    output logic [NUM_CH-1:0]            ext_req,
    output logic [NUM_CH*EXT_ADDR_W-1:0] ext_addr,
    input  logic [NUM_CH*DATA_W-1:0]     ext_data,
    input  logic [NUM_CH-1:0]            ext_ack,
    output logic                         busy
`ifdef CNT_TIMEOUT_EN
    ,
    output logic                         timeout_sticky
`endif
);

    // A single channel still gets a one-bit field so that bit is checked as "above the field".
    localparam int          CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          UPPER_LSB  = CH_SEL_LSB + CH_W;
    localparam logic [31:0] LOCAL_MASK = (32'd1 << CH_SEL_LSB) - 32'd1;

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [CH_W-1:0]       ch_q;
    logic [EXT_ADDR_W-1:0] local_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [DATA_W-1:0]     rdata_nxt;
    logic [1:0]            rresp_q;
    logic [1:0]            rresp_nxt;

    logic [CH_W-1:0]       dec_ch;
    logic [EXT_ADDR_W-1:0] dec_local;
    logic                  dec_err;
    logic                  ar_hs;
    logic                  ack_sel;
    logic [DATA_W-1:0]     data_sel;

    assign dec_ch    = s_axil.s_araddr[CH_SEL_LSB +: CH_W];
    assign dec_local = EXT_ADDR_W'(s_axil.s_araddr & LOCAL_MASK);
    assign dec_err   = ((s_axil.s_araddr >> UPPER_LSB) != 32'd0) || (32'(dec_ch) >= NUM_CH);

    assign ar_hs    = (state == IDLE) && s_axil.s_arvalid;
    assign ack_sel  = ext_ack[ch_q];
    assign data_sel = ext_data[ch_q*DATA_W +: DATA_W];

    assign s_axil.s_arready = (state == IDLE);
    assign s_axil.s_rvalid  = (state == RESP);
    assign s_axil.s_rdata   = rdata_q;
    assign s_axil.s_rresp   = rresp_q;
    assign busy             = (state != IDLE);

    // Request is decoded straight from the state so a reset drops it without waiting for a clock.
    assign ext_req = (state == REQ) ? (NUM_CH'(1) << ch_q) : '0;

`ifdef CNT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             waiting;
    logic             timeout_hit;

    assign waiting = (state == WAIT_LOW) || (state == REQ) || (state == RELEASE);
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    always_ff @(posedge coreclk or negedge corerstn) begin
        if (!corerstn) begin
            state   <= IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            state   <= state_nxt;
            rdata_q <= rdata_nxt;
            rresp_q <= rresp_nxt;
        end
    end

    // Transaction context is captured at the AR handshake and held until the next one.
    always_ff @(posedge coreclk or negedge corerstn) begin
        if (!corerstn) begin
            ch_q    <= '0;
            local_q <= '0;
        end else if (ar_hs) begin
            ch_q    <= dec_ch;
            local_q <= dec_local;
        end
    end

    // Only the selected slice is rewritten; idle channels keep their last address.
    always_ff @(posedge coreclk or negedge corerstn) begin
        if (!corerstn) begin
            ext_addr <= '0;
        end else if ((state == WAIT_LOW) && (state_nxt == REQ)) begin
            ext_addr[ch_q*EXT_ADDR_W +: EXT_ADDR_W] <= local_q;
        end
    end

    always_comb begin
        state_nxt = state;
        rdata_nxt = rdata_q;
        rresp_nxt = rresp_q;
`ifdef CNT_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    if (dec_err) begin
                        state_nxt = RESP;
                        rdata_nxt = '0;
                        rresp_nxt = RESP_DECERR;
                    end else begin
                        state_nxt = WAIT_LOW;
                    end
                end
            end
            WAIT_LOW: begin
                if (!ack_sel) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack_sel) begin
                    state_nxt = RELEASE;
                    rdata_nxt = data_sel;
                    rresp_nxt = RESP_OKAY;
                end
            end
            RELEASE: begin
                if (!ack_sel) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (s_axil.s_rready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef CNT_TIMEOUT_EN
        // Real progress on the final allowed cycle wins over the timeout.
        if (waiting && (state_nxt == state) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
            state_nxt   = RESP;
            rdata_nxt   = TIMEOUT_DATA;
            rresp_nxt   = RESP_SLVERR;
            timeout_hit = 1'b1;
        end
`endif
    end

`ifdef CNT_TIMEOUT_EN
    always_ff @(posedge coreclk or negedge corerstn) begin
        if (!corerstn) begin
            tmo_cnt <= '0;
        end else if (state_nxt != state) begin
            tmo_cnt <= '0;
        end else if (waiting) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge coreclk or negedge corerstn) begin
        if (!corerstn) begin
            timeout_sticky <= 1'b0;
        end else if (timeout_hit) begin
            timeout_sticky <= 1'b1;
        end
    end
`endif

    axil_cnt_wr_sink u_wr_sink (
        .coreclk  (coreclk),
        .corerstn (corerstn),
        .bus      (s_axil)
    );

endmodule

// File: tb/tb_axil_cnt_bridge.sv
// Directed bench for axil_cnt_bridge: a read vector table plus hand-written
// sequences for concurrent writes, timeouts (CNT_TIMEOUT_EN) and mid-REQ reset.
module tb_axil_cnt_bridge;

    localparam int NCH = 2;

    typedef struct {
        logic [31:0] addr;
        int          ch;
        int          ack_dly;
        logic [31:0] data;
        int          stall;
        bit          stuck;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_reqs;
        logic [31:0] exp_addr;
    } vec_t;

    logic              coreclk;
    logic              corerstn;
    logic [NCH-1:0]    ext_req;
    logic [NCH*32-1:0] ext_addr;
    logic [NCH*32-1:0] ext_data;
    logic [NCH-1:0]    ext_ack;
    logic              busy;
`ifdef CNT_TIMEOUT_EN
    logic              timeout_sticky;
`endif

    int total;
    int bad;

    vec_t vecs [6];

    axil_cnt_bridge_if bus ();

    axil_cnt_bridge #(
        .NUM_CH      (NCH),
        .EXT_ADDR_W  (32),
        .DATA_W      (32),
        .CH_SEL_LSB  (16),
        .TIMEOUT_CYC (16)
    ) dut (
        .coreclk        (coreclk),
        .corerstn       (corerstn),
        .s_axil         (bus),
        .ext_req        (ext_req),
        .ext_addr       (ext_addr),
        .ext_data       (ext_data),
        .ext_ack        (ext_ack),
        .busy           (busy)
`ifdef CNT_TIMEOUT_EN
        ,
        .timeout_sticky (timeout_sticky)
`endif
    );

    // Free-running core clock, 10 time units per cycle.
    initial coreclk = 1'b0;
    always #5 coreclk = ~coreclk;

    // Hard stop in case some wait below is never satisfied.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issues one read and plays the external device for the target channel.
    task automatic applyStimulus(input vec_t v,
                                 output logic [31:0] got_data, output logic [1:0] got_resp,
                                 output int lat, output int reqs, output logic [31:0] seen_addr,
                                 output bit other_req, output bit stall_ok,
                                 output bit got_valid, output bit busy_seen);
        int cyc;
        logic [NCH-1:0] own;
        got_data  = '0;
        got_resp  = '0;
        lat       = 0;
        reqs      = 0;
        seen_addr = '0;
        other_req = 1'b0;
        stall_ok  = 1'b1;
        got_valid = 1'b0;
        busy_seen = 1'b0;
        own = NCH'(1) << v.ch;
        ext_data[v.ch*32 +: 32] = 32'hBAD0_0BAD;
        if (v.stuck) ext_ack[v.ch] = 1'b1;
        bus.s_araddr  = v.addr;
        bus.s_arvalid = 1'b1;
        cyc = 0;
        while (!bus.s_arready && cyc < 20) begin
            @(posedge coreclk); #1;
            cyc++;
        end
        @(posedge coreclk); #1;
        bus.s_arvalid = 1'b0;
        lat = 1;
        cyc = 0;
        while (!bus.s_rvalid && cyc < 200) begin
            if ((ext_req & ~own) != '0) other_req = 1'b1;
            if (ext_req[v.ch]) begin
                if (reqs == 0) seen_addr = ext_addr[v.ch*32 +: 32];
                if (reqs == v.ack_dly) begin
                    ext_ack[v.ch]           = 1'b1;
                    ext_data[v.ch*32 +: 32] = v.data;
                end
                reqs++;
            end else if (ext_ack[v.ch] && !v.stuck) begin
                ext_ack[v.ch] = 1'b0;
            end
            @(posedge coreclk); #1;
            lat++;
            cyc++;
        end
        got_valid = bus.s_rvalid;
        if (got_valid) begin
            got_data  = bus.s_rdata;
            got_resp  = bus.s_rresp;
            busy_seen = busy;
            for (int i = 0; i < v.stall; i++) begin
                @(posedge coreclk); #1;
                if (!bus.s_rvalid || bus.s_rdata !== got_data || bus.s_rresp !== got_resp || bus.s_arready)
                    stall_ok = 1'b0;
            end
            bus.s_rready = 1'b1;
            @(posedge coreclk); #1;
            bus.s_rready = 1'b0;
        end
    endtask

    task automatic runVector(input string tag, input vec_t v);
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] a;
        int          lat;
        int          reqs;
        bit          other;
        bit          stable;
        bit          valid;
        bit          bsy;
        applyStimulus(v, d, r, lat, reqs, a, other, stable, valid, bsy);
        checkOutput({tag, "_rvalid"}, 32'(valid), 32'd1);
        checkOutput({tag, "_rresp"}, 32'(r), 32'(v.exp_resp));
        checkOutput({tag, "_rdata"}, d, v.exp_data);
        checkOutput({tag, "_latency"}, lat, v.exp_lat);
        checkOutput({tag, "_req_cycles"}, reqs, v.exp_reqs);
        checkOutput({tag, "_foreign_req"}, 32'(other), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bsy), 32'd1);
        if (v.exp_reqs > 0) checkOutput({tag, "_ext_addr"}, a, v.exp_addr);
        if (v.stall > 0) checkOutput({tag, "_stall_stable"}, 32'(stable), 32'd1);
        checkOutput({tag, "_post_rdy_busy_rvalid"}, {29'd0, bus.s_arready, busy, bus.s_rvalid}, 32'b100);
    endtask

    // AW first, W five cycles later, then one SLVERR response.
    task automatic writeSeq();
        int cyc;
        @(posedge coreclk); #1;
        bus.s_awaddr  = 32'h0000_0040;
        bus.s_awvalid = 1'b1;
        @(posedge coreclk); #1;
        bus.s_awvalid = 1'b0;
        checkOutput("wr_after_aw", {29'd0, bus.s_awready, bus.s_wready, bus.s_bvalid}, 32'b010);
        repeat (4) begin
            @(posedge coreclk); #1;
        end
        bus.s_wdata  = 32'hFFFF_FFFF;
        bus.s_wstrb  = 4'hF;
        bus.s_wvalid = 1'b1;
        @(posedge coreclk); #1;
        bus.s_wvalid = 1'b0;
        checkOutput("wr_wready_low", 32'(bus.s_wready), 32'd0);
        cyc = 0;
        while (!bus.s_bvalid && cyc < 5) begin
            @(posedge coreclk); #1;
            cyc++;
        end
        checkOutput("wr_bvalid", 32'(bus.s_bvalid), 32'd1);
        checkOutput("wr_bresp", 32'(bus.s_bresp), 32'h2);
        bus.s_bready = 1'b1;
        @(posedge coreclk); #1;
        bus.s_bready = 1'b0;
        checkOutput("wr_after_b", {29'd0, bus.s_awready, bus.s_wready, bus.s_bvalid}, 32'b110);
        repeat (2) begin
            @(posedge coreclk); #1;
        end
        checkOutput("wr_single_b", 32'(bus.s_bvalid), 32'd0);
    endtask

    initial begin
        vec_t rv;
        int   cyc;
        total = 0;
        bad   = 0;
        //            addr           ch dly data           stl stk resp   exp_data      lat reqs addr
        vecs[0] = '{32'h0001_0040, 1, 3, 32'h1234_5678, 0, 0, 2'b00, 32'h1234_5678, 7, 4, 32'h0000_0040};
        vecs[1] = '{32'h0000_0004, 0, 0, 32'hA5A5_0001, 0, 0, 2'b00, 32'hA5A5_0001, 4, 1, 32'h0000_0004};
        vecs[2] = '{32'h0002_0000, 0, 0, 32'h1111_1111, 0, 0, 2'b11, 32'h0000_0000, 1, 0, 32'h0000_0000};
        vecs[3] = '{32'h8001_0000, 0, 0, 32'h2222_2222, 2, 0, 2'b11, 32'h0000_0000, 1, 0, 32'h0000_0000};
        vecs[4] = '{32'h0001_FFFC, 1, 1, 32'hCAFE_BABE, 10, 0, 2'b00, 32'hCAFE_BABE, 5, 2, 32'h0000_FFFC};
        vecs[5] = '{32'h0000_0010, 0, 2, 32'h0000_0000, 0, 0, 2'b00, 32'h0000_0000, 6, 3, 32'h0000_0010};

        corerstn      = 1'b0;
        ext_data      = '0;
        ext_ack       = '0;
        bus.s_araddr  = '0;
        bus.s_arvalid = 1'b0;
        bus.s_rready  = 1'b0;
        bus.s_awaddr  = '0;
        bus.s_awvalid = 1'b0;
        bus.s_wdata   = '0;
        bus.s_wstrb   = '0;
        bus.s_wvalid  = 1'b0;
        bus.s_bready  = 1'b0;
        repeat (3) @(posedge coreclk);
        #1 corerstn = 1'b1;
        @(posedge coreclk); #1;

        $display("[TB] reset state");
        checkOutput("rst_readies", {29'd0, bus.s_arready, bus.s_awready, bus.s_wready}, 32'b111);
        checkOutput("rst_valids_busy", {29'd0, bus.s_rvalid, bus.s_bvalid, busy}, 32'b000);
        checkOutput("rst_ext_req", 32'(ext_req), 32'd0);
        checkOutput("rst_resps", {28'd0, bus.s_rresp, bus.s_bresp}, 32'd0);
        checkOutput("rst_rdata", bus.s_rdata, 32'd0);
        checkOutput("rst_ext_addr0", ext_addr[31:0], 32'd0);
        checkOutput("rst_ext_addr1", ext_addr[63:32], 32'd0);
`ifdef CNT_TIMEOUT_EN
        checkOutput("rst_sticky", 32'(timeout_sticky), 32'd0);
`endif

        $display("[TB] read vector table");
        for (int i = 0; i < 6; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        $display("[TB] write during read");
        rv = '{32'h0000_0008, 0, 5, 32'h0F0F_F0F0, 0, 0, 2'b00, 32'h0F0F_F0F0, 9, 6, 32'h0000_0008};
        fork
            runVector("wr_rd", rv);
            writeSeq();
        join

`ifdef CNT_TIMEOUT_EN
        $display("[TB] timeouts");
        rv = '{32'h0000_0020, 0, 1000, 32'h3333_3333, 0, 0, 2'b10, 32'hDEAD_DEAD, 18, 16, 32'h0000_0020};
        runVector("tmo_req", rv);
        checkOutput("tmo_sticky", 32'(timeout_sticky), 32'd1);
        rv = '{32'h0000_0024, 0, 1000, 32'h4444_4444, 0, 1, 2'b10, 32'hDEAD_DEAD, 17, 0, 32'h0000_0000};
        runVector("tmo_wait_low", rv);
        checkOutput("tmo_sticky_held", 32'(timeout_sticky), 32'd1);
        ext_ack = '0;
        @(posedge coreclk); #1;
`endif

        $display("[TB] reset during REQ");
        bus.s_araddr  = 32'h0001_0008;
        bus.s_arvalid = 1'b1;
        @(posedge coreclk); #1;
        bus.s_arvalid = 1'b0;
        cyc = 0;
        while (!ext_req[1] && cyc < 10) begin
            @(posedge coreclk); #1;
            cyc++;
        end
        checkOutput("mid_rst_req_before", 32'(ext_req), 32'b10);
        #3 corerstn = 1'b0;
        #1;
        checkOutput("mid_rst_req_async", 32'(ext_req), 32'd0);
        checkOutput("mid_rst_arready_busy", {30'd0, bus.s_arready, busy}, 32'b10);
        checkOutput("mid_rst_addr1", ext_addr[63:32], 32'd0);
`ifdef CNT_TIMEOUT_EN
        checkOutput("mid_rst_sticky", 32'(timeout_sticky), 32'd0);
`endif
        @(negedge coreclk);
        corerstn = 1'b1;
        @(posedge coreclk); #1;
        checkOutput("post_rst_arready", 32'(bus.s_arready), 32'd1);
        rv = '{32'h0001_0100, 1, 0, 32'h5EED_0001, 0, 0, 2'b00, 32'h5EED_0001, 4, 1, 32'h0000_0100};
        runVector("post_rst", rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
